// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with a small byte FIFO and DATA/STATUS registers on a read-only port.
// A byte is readable the cycle after its stop-bit sample; a full FIFO drops new bytes and sets OVR.
module uart_rx_mmio #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [31:0] d_addr,
    input  logic        d_re,
    output logic [31:0] d_rdata,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_LOAD   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD    = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   DATA_ADDR   = BASE_ADDR + 32'd4;
    localparam logic [31:0]   STAT_ADDR   = BASE_ADDR + 32'd8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_sync;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovr;
    logic          ferr;

    logic sample;
    logic push;
    logic ferr_set;
    logic empty;
    logic full;
    logic pop;
    logic wr_en;
    logic ovr_set;
    logic stat_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign sample   = (cnt == '0);
    assign push     = (state == STOP) && sample && rx_sync;
    assign ferr_set = (state == STOP) && sample && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state   <= START;
                        bit_cnt <= '0;
                        cnt     <= HALF_LOAD;
                    end
                end
                START: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_sync) begin
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                        cnt   <= BIT_LOAD;
                    end
                end
                DATA: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {rx_sync, shreg[7:1]};
                        cnt   <= BIT_LOAD;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (!sample) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= rx_sync ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_COUNT);
    assign pop     = d_re && (d_addr == DATA_ADDR) && !empty;
    // A pop on a full FIFO frees the slot in the same cycle, so the push still lands.
    assign wr_en   = push && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign stat_rd = d_re && (d_addr == STAT_ADDR);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A set event in the same cycle as a STATUS read keeps the bit set.
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (stat_rd) begin
                ovr <= 1'b0;
            end
            if (ferr_set) begin
                ferr <= 1'b1;
            end else if (stat_rd) begin
                ferr <= 1'b0;
            end
        end
    end

    always_comb begin
        d_rdata = 32'h0;
        if (d_addr == DATA_ADDR) begin
            if (!empty) begin
                d_rdata = {24'h0, mem[rd_ptr]};
            end
        end else if (d_addr == STAT_ADDR) begin
            d_rdata = {16'h0, 8'(count), 5'h0, ferr, ovr, !empty};
        end
    end

    assign irq = !empty;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scenario bench for uart_rx_mmio: serial frames in, register reads out, scoreboard of expected bytes.
module tb_uart_rx_mmio;

    localparam int          C      = 8;
    localparam int          D      = 4;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'd4;
    localparam logic [31:0] A_STAT = BASE + 32'd8;
    // Negedges from the start-bit drive to the one just before the stop-bit sample edge.
    localparam int          STOP_NEG = 3 + C / 2 + 9 * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] d_addr = 32'h0;
    logic        d_re = 1'b0;
    logic [31:0] d_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    uart_rx_mmio #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .d_addr(d_addr),
        .d_re(d_re),
        .d_rdata(d_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_cycles);
        @(negedge clk);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_cycles) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic re, output logic [31:0] v);
        @(negedge clk);
        d_addr = a;
        d_re   = re;
        #1 v = d_rdata;
        @(posedge clk);
        #1 d_re = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        d_addr = A_STAT; #1;
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", d_rdata); end
        d_addr = A_DATA; #1;
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", d_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL post_reset_status: got %h want 0", v); end
    endtask

    task automatic test_single();
        logic [31:0] v;
        logic [7:0]  e;
        sb.push_back(8'hA5);
        d_addr = A_DATA;
        fork
            send_frame(8'hA5, 1'b1, C);
            begin
                repeat (STOP_NEG) @(negedge clk);
                #1;
                checks++; if (irq !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL pre_stop: irq %b data %h want 0 0", irq, d_rdata); end
                @(negedge clk);
                #1;
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL latency_irq: got %b want 1", irq); end
                checks++; if (d_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL latency_data: got %h want 000000a5", d_rdata); end
            end
        join
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0000_0101) begin errors++; $display("FAIL single_status: got %h want 00000101", v); end
        rd(BASE + 32'hC, 1'b1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL other_addr: got %h want 0", v); end
        rd(BASE, 1'b1, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL base_addr: got %h want 0", v); end
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        rd(A_DATA, 1'b1, v);
        checks++; if (v !== {24'h0, e}) begin errors++; $display("FAIL single_pop: got %h want %h", v, {24'h0, e}); end
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL single_after_pop: got %h want 0", v); end
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        logic [7:0]  e;
        for (int i = 1; i <= 5; i++) begin
            if (i <= D) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1, C);
        end
        rd(A_STAT, 1'b1, v);
        checks++; if (v !== 32'h0000_0403) begin errors++; $display("FAIL ovr_status: got %h want 00000403", v); end
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL ovr_cleared: got %h want 00000401", v); end
        for (int i = 0; i < D; i++) begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
            rd(A_DATA, 1'b1, v);
            checks++; if (v !== {24'h0, e}) begin errors++; $display("FAIL ovr_pop%0d: got %h want %h", i, v, {24'h0, e}); end
        end
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovr_drained: got %h want 0", v); end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        logic [7:0]  e;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h want 0", v); end
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, C);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        rd(A_DATA, 1'b1, v);
        checks++; if (v !== {24'h0, e}) begin errors++; $display("FAIL glitch_next: got %h want %h", v, {24'h0, e}); end
    endtask

    task automatic test_break();
        logic [31:0] v;
        logic [7:0]  e;
        send_frame(8'h3C, 1'b0, 40);
        repeat (10) @(negedge clk);
        rd(A_STAT, 1'b1, v);
        checks++; if (v !== 32'h0000_0004) begin errors++; $display("FAIL break_ferr: got %h want 00000004", v); end
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL break_cleared: got %h want 0", v); end
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, C);
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0000_0101) begin errors++; $display("FAIL break_next_status: got %h want 00000101", v); end
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        rd(A_DATA, 1'b1, v);
        checks++; if (v !== {24'h0, e}) begin errors++; $display("FAIL break_next_data: got %h want %h", v, {24'h0, e}); end
    endtask

    task automatic test_full_pop();
        logic [31:0] v;
        logic [7:0]  e;
        for (int i = 0; i < D; i++) begin
            sb.push_back(8'(8'h10 + i));
            send_frame(8'(8'h10 + i), 1'b1, C);
        end
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL full_status: got %h want 00000401", v); end
        sb.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1, C);
            begin
                repeat (STOP_NEG) @(negedge clk);
                d_addr = A_DATA;
                d_re   = 1'b1;
                e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
                #1;
                checks++; if (d_rdata !== {24'h0, e}) begin errors++; $display("FAIL full_pop_head: got %h want %h", d_rdata, {24'h0, e}); end
                @(posedge clk);
                #1 d_re = 1'b0;
            end
        join
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL full_pop_status: got %h want 00000401", v); end
        for (int i = 0; i < D; i++) begin
            e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
            rd(A_DATA, 1'b1, v);
            checks++; if (v !== {24'h0, e}) begin errors++; $display("FAIL full_pop_drain%0d: got %h want %h", i, v, {24'h0, e}); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        logic [7:0]  b;
        logic [7:0]  e;
        b = 8'h55;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, C);
        @(negedge clk);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = b[4];
        repeat (C / 2) @(negedge clk);
        d_addr = A_STAT;
        rst_n  = 1'b0;
        sb.delete();
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", irq); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h want 0", d_rdata); end
        d_addr = A_DATA; #1;
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want 0", d_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx    = 1'b1;
        repeat (15 * C) @(negedge clk);
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midreset_no_byte: got %h want 0", v); end
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, C);
        e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
        rd(A_DATA, 1'b1, v);
        checks++; if (v !== {24'h0, e}) begin errors++; $display("FAIL midreset_next: got %h want %h", v, {24'h0, e}); end
        rd(A_STAT, 1'b0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midreset_final: got %h want 0", v); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overrun();
        test_glitch();
        test_break();
        test_full_pop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
